// File: rtl/ddr_fifo_sch_pkg.sv
// Shared encodings for the DDR ring FIFO scheduler: FSM state codes, grant side and a saturating counter helper.
package ddr_fifo_sch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_BUSY = 2'd1;
  localparam logic [1:0] ST_RD_BUSY = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  localparam logic GNT_WR = 1'b1;
  localparam logic GNT_RD = 1'b0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ddr_sch_ring_ptr.sv
// Ring pointer in beat units: advances one burst per strobe, wraps to 0 at DDR_SIZE, address out is registered-pointer based.
// Latency: advance visible the cycle after adv; no backpressure (strobe is always accepted).
module ddr_sch_ring_ptr
  import ddr_fifo_sch_pkg::*;
#(
  parameter int                     DDR_ADDR_WD = 30,
  parameter logic [DDR_ADDR_WD-1:0] DDR_BASE    = '0,
  parameter logic [31:0]            DDR_SIZE    = 32'h1000,
  parameter int                     BURST_LEN   = 64
) (
  input  logic                   ddr_clk,
  input  logic                   ddr_rst_n,
  input  logic                   clr,
  input  logic                   adv,
  output logic [DDR_ADDR_WD-1:0] addr
);

  localparam logic [31:0] BL = 32'(BURST_LEN);

  logic [31:0] ptr;

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr + BL == DDR_SIZE) ? 32'd0 : ptr + BL;
    end
  end

  // Each beat is 8 app_addr units wide.
  assign addr = DDR_ADDR_WD'(32'(DDR_BASE) + (ptr << 3));

endmodule

// File: rtl/ddr_fifo_sch.sv
// DDR3 ring FIFO burst scheduler: round-robin write/read grants with write urgency, one registered 1-cycle req per burst.
// Stats counters are built only with DDR_FIFO_SCH_STAT_EN; no grant while burst_idle=0, sch_en=0 or the FSM is busy.
module ddr_fifo_sch
  import ddr_fifo_sch_pkg::*;
#(
  parameter int                     DDR_ADDR_WD  = 30,
  parameter logic [DDR_ADDR_WD-1:0] DDR_BASE     = 30'h0,
  parameter logic [31:0]            DDR_SIZE     = 32'h1000,
  parameter int                     BURST_LEN    = 64,
  parameter int                     FIFO_CNT_WD  = 12,
  parameter int                     WR_URGENT_TH = 1536,
  parameter int                     RD_FREE_TH   = 128
) (
  input  logic                   ddr_clk,
  input  logic                   ddr_rst_n,
  input  logic                   cfg_rst,
  input  logic                   sch_en,
  input  logic [FIFO_CNT_WD-1:0] wfifo_cnt,
  input  logic [FIFO_CNT_WD-1:0] rfifo_free,
  input  logic                   burst_idle,
  output logic                   wr_ddr_req,
  output logic [7:0]             wr_ddr_len,
  output logic [DDR_ADDR_WD-1:0] wr_ddr_addr,
  input  logic                   wr_ddr_finish,
  output logic                   rd_ddr_req,
  output logic [7:0]             rd_ddr_len,
  output logic [DDR_ADDR_WD-1:0] rd_ddr_addr,
  input  logic                   rd_ddr_finish,
  output logic [31:0]            ddr_used,
  output logic                   ddr_full,
  output logic                   ddr_empty,
  output logic [31:0]            wr_burst_cnt,
  output logic [31:0]            rd_burst_cnt,
  output logic [31:0]            stall_cnt
);

  localparam logic [31:0] BL     = 32'(BURST_LEN);
  localparam logic [31:0] URG_TH = 32'(WR_URGENT_TH);
  localparam logic [31:0] FREE_TH = 32'(RD_FREE_TH);

  logic [1:0]  state;
  logic        last_grant;
  logic [31:0] used_q;
  logic        wr_req_q, rd_req_q;
  logic        wfifo_big, wr_ok, rd_ok, wr_urgent, can_grant;
  logic        gnt_wr, gnt_rd, wr_done, rd_done;

  assign wfifo_big = 32'(wfifo_cnt) >= BL;
  assign wr_ok     = wfifo_big && (used_q <= DDR_SIZE - BL);
  assign rd_ok     = (used_q >= BL) && (32'(rfifo_free) >= FREE_TH);
  assign wr_urgent = wr_ok && (32'(wfifo_cnt) >= URG_TH);
  assign can_grant = (state == ST_IDLE) && sch_en && burst_idle;
  assign wr_done   = (state == ST_WR_BUSY) && wr_ddr_finish;
  assign rd_done   = (state == ST_RD_BUSY) && rd_ddr_finish;

  // Urgent write first; otherwise prefer the side that did not win last time.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (can_grant) begin
      if (wr_urgent) begin
        gnt_wr = 1'b1;
      end else if (last_grant == GNT_RD) begin
        if (wr_ok) gnt_wr = 1'b1;
        else if (rd_ok) gnt_rd = 1'b1;
      end else begin
        if (rd_ok) gnt_rd = 1'b1;
        else if (wr_ok) gnt_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      state      <= ST_IDLE;
      last_grant <= GNT_RD;
      used_q     <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
    end else if (cfg_rst) begin
      state      <= ST_IDLE;
      last_grant <= GNT_RD;
      used_q     <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      wr_req_q <= gnt_wr;
      rd_req_q <= gnt_rd;
      case (state)
        ST_IDLE: begin
          if (gnt_wr) begin
            state      <= ST_WR_BUSY;
            last_grant <= GNT_WR;
          end else if (gnt_rd) begin
            // Reserve the data at grant so it can never be read twice.
            state      <= ST_RD_BUSY;
            last_grant <= GNT_RD;
            used_q     <= used_q - BL;
          end
        end
        ST_WR_BUSY: begin
          if (wr_ddr_finish) begin
            state  <= ST_GAP;
            used_q <= used_q + BL;
          end
        end
        ST_RD_BUSY: begin
          if (rd_ddr_finish) state <= ST_GAP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ddr_sch_ring_ptr #(
    .DDR_ADDR_WD(DDR_ADDR_WD), .DDR_BASE(DDR_BASE), .DDR_SIZE(DDR_SIZE), .BURST_LEN(BURST_LEN)
  ) u_wr_ptr (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .clr(cfg_rst), .adv(wr_done), .addr(wr_ddr_addr)
  );

  ddr_sch_ring_ptr #(
    .DDR_ADDR_WD(DDR_ADDR_WD), .DDR_BASE(DDR_BASE), .DDR_SIZE(DDR_SIZE), .BURST_LEN(BURST_LEN)
  ) u_rd_ptr (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .clr(cfg_rst), .adv(rd_done), .addr(rd_ddr_addr)
  );

  assign wr_ddr_req = wr_req_q;
  assign rd_ddr_req = rd_req_q;
  assign wr_ddr_len = 8'(BURST_LEN);
  assign rd_ddr_len = 8'(BURST_LEN);
  assign ddr_used   = used_q;
  assign ddr_full   = used_q > DDR_SIZE - BL;
  assign ddr_empty  = used_q < BL;

`ifdef DDR_FIFO_SCH_STAT_EN
  logic [31:0] wr_cnt_q, rd_cnt_q, stall_q;
  logic        stall_hit;

  assign stall_hit = (state == ST_IDLE) && sch_en && wfifo_big && ddr_full;

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      stall_q  <= '0;
    end else if (cfg_rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      if (gnt_wr)    wr_cnt_q <= sat_inc(wr_cnt_q);
      if (gnt_rd)    rd_cnt_q <= sat_inc(rd_cnt_q);
      if (stall_hit) stall_q  <= sat_inc(stall_q);
    end
  end

  assign wr_burst_cnt = wr_cnt_q;
  assign rd_burst_cnt = rd_cnt_q;
  assign stall_cnt    = stall_q;
`else
  assign wr_burst_cnt = '0;
  assign rd_burst_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_ddr_fifo_sch.sv
// Directed bench for ddr_fifo_sch with a 256-beat ring; the bench plays the part of mem_ctrl_inf.
module tb_ddr_fifo_sch;

  logic        ddr_clk = 1'b0;
  logic        ddr_rst_n, cfg_rst, sch_en, burst_idle;
  logic [11:0] wfifo_cnt, rfifo_free;
  logic        wr_ddr_req, rd_ddr_req, wr_ddr_finish, rd_ddr_finish;
  logic [7:0]  wr_ddr_len, rd_ddr_len;
  logic [29:0] wr_ddr_addr, rd_ddr_addr;
  logic [31:0] ddr_used, wr_burst_cnt, rd_burst_cnt, stall_cnt;
  logic        ddr_full, ddr_empty;

  int n_chk = 0;
  int n_err = 0;

  always #5 ddr_clk = ~ddr_clk;

  ddr_fifo_sch #(.DDR_SIZE(32'd256)) dut (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .cfg_rst(cfg_rst), .sch_en(sch_en),
    .wfifo_cnt(wfifo_cnt), .rfifo_free(rfifo_free), .burst_idle(burst_idle),
    .wr_ddr_req(wr_ddr_req), .wr_ddr_len(wr_ddr_len), .wr_ddr_addr(wr_ddr_addr),
    .wr_ddr_finish(wr_ddr_finish),
    .rd_ddr_req(rd_ddr_req), .rd_ddr_len(rd_ddr_len), .rd_ddr_addr(rd_ddr_addr),
    .rd_ddr_finish(rd_ddr_finish),
    .ddr_used(ddr_used), .ddr_full(ddr_full), .ddr_empty(ddr_empty),
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      seen = seen | wr_ddr_req | rd_ddr_req;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  // Wait for a request, check it, then act as the controller: busy, finish pulse, idle again.
  task automatic run_burst(input bit is_wr, input logic [31:0] exp_addr,
                           input logic [31:0] exp_used, input int max_wait, input string tag);
    int n;
    n = 0;
    while (!(is_wr ? wr_ddr_req : rd_ddr_req) && n < max_wait) begin
      tick();
      n++;
    end
    chk({tag, "_req"},   32'(is_wr ? wr_ddr_req : rd_ddr_req), 32'd1);
    chk({tag, "_other"}, 32'(is_wr ? rd_ddr_req : wr_ddr_req), 32'd0);
    chk({tag, "_addr"},  32'(is_wr ? wr_ddr_addr : rd_ddr_addr), exp_addr);
    chk({tag, "_len"},   32'(is_wr ? wr_ddr_len : rd_ddr_len), 32'd64);
    if (!is_wr) chk({tag, "_used_at_req"}, ddr_used, exp_used);
    burst_idle = 1'b0;
    tick();
    chk({tag, "_pulse"}, 32'(is_wr ? wr_ddr_req : rd_ddr_req), 32'd0);
    tick();
    tick();
    if (is_wr) wr_ddr_finish = 1'b1;
    else       rd_ddr_finish = 1'b1;
    tick();
    wr_ddr_finish = 1'b0;
    rd_ddr_finish = 1'b0;
    burst_idle    = 1'b1;
    if (is_wr) chk({tag, "_used_after"}, ddr_used, exp_used);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [31:0] exp_wr_cnt, exp_rd_cnt, exp_stall;
    int n;

    ddr_rst_n = 1'b0; cfg_rst = 1'b0; sch_en = 1'b0; burst_idle = 1'b1;
    wfifo_cnt = '0; rfifo_free = '0; wr_ddr_finish = 1'b0; rd_ddr_finish = 1'b0;
    repeat (3) tick();
    chk("rst_wr_req", 32'(wr_ddr_req), 32'd0);
    chk("rst_rd_req", 32'(rd_ddr_req), 32'd0);
    chk("rst_used",   ddr_used, 32'd0);
    chk("rst_empty",  32'(ddr_empty), 32'd1);
    chk("rst_full",   32'(ddr_full), 32'd0);
    chk("rst_wr_addr", 32'(wr_ddr_addr), 32'd0);
    chk("rst_stall",  stall_cnt, 32'd0);
    ddr_rst_n = 1'b1;
    tick();

    // Write only: one burst, then nothing readable downstream.
    sch_en = 1'b1; wfifo_cnt = 12'd64; rfifo_free = 12'd0;
    run_burst(1'b1, 32'h000, 32'd64, 8, "t1_wr");
    wfifo_cnt = 12'd0;
    quiet(6, "t1_quiet");
    chk("t1_empty", 32'(ddr_empty), 32'd0);

    // Urgent write beats the read that round-robin would otherwise pick.
    wfifo_cnt = 12'd2000; rfifo_free = 12'd200;
    run_burst(1'b1, 32'h200, 32'd128, 8, "t2_urgent_wr");
    wfifo_cnt = 12'd100;
    run_burst(1'b0, 32'h000, 32'd64,  8, "t2_rd1");
    run_burst(1'b1, 32'h400, 32'd128, 8, "t2_wr2");
    run_burst(1'b0, 32'h200, 32'd64,  8, "t2_rd2");

    // Write pointer wraps after the last burst slot of the ring.
    run_burst(1'b1, 32'h600, 32'd128, 8, "t3_wr_top");
    run_burst(1'b0, 32'h400, 32'd64,  8, "t3_rd");
    rfifo_free = 12'd0;
    run_burst(1'b1, 32'h000, 32'd128, 8, "t3_wr_wrap");
    run_burst(1'b1, 32'h200, 32'd192, 8, "t3_wr_a");
    run_burst(1'b1, 32'h400, 32'd256, 8, "t3_wr_b");

    // Ring full: write blocked, stall counted on every IDLE cycle.
    chk("t4_full", 32'(ddr_full), 32'd1);
    quiet(10, "t4_no_req");
`ifdef DDR_FIFO_SCH_STAT_EN
    exp_wr_cnt = 32'd7; exp_rd_cnt = 32'd3; exp_stall = 32'd9;
`else
    exp_wr_cnt = 32'd0; exp_rd_cnt = 32'd0; exp_stall = 32'd0;
`endif
    chk("t4_stall_cnt", stall_cnt, exp_stall);
    chk("t4_wr_cnt", wr_burst_cnt, exp_wr_cnt);
    chk("t4_rd_cnt", rd_burst_cnt, exp_rd_cnt);

    // Read backpressure right at the free-space threshold.
    rfifo_free = 12'd127;
    quiet(6, "t6_no_rd");
    rfifo_free = 12'd128;
    run_burst(1'b0, 32'h600, 32'd192, 2, "t6_rd");
    wfifo_cnt = 12'd0; rfifo_free = 12'd200;

    // Abort mid-read; read pointer has wrapped to 0 for this grant.
    n = 0;
    while (!rd_ddr_req && n < 8) begin
      tick();
      n++;
    end
    chk("t5_rd_req", 32'(rd_ddr_req), 32'd1);
    chk("t5_rd_addr", 32'(rd_ddr_addr), 32'd0);
    chk("t5_used_at_req", ddr_used, 32'd128);
    burst_idle = 1'b0;
    repeat (3) tick();
    cfg_rst = 1'b1;
    tick();
    cfg_rst = 1'b0;
    chk("t5_used", ddr_used, 32'd0);
    chk("t5_wr_addr", 32'(wr_ddr_addr), 32'd0);
    chk("t5_rd_cnt_clr", rd_burst_cnt, 32'd0);
    burst_idle = 1'b1;
    rd_ddr_finish = 1'b1;
    wr_ddr_finish = 1'b1;
    tick();
    rd_ddr_finish = 1'b0;
    wr_ddr_finish = 1'b0;
    quiet(3, "t5_late_finish_no_req");
    chk("t5_rd_addr_hold", 32'(rd_ddr_addr), 32'd0);
    chk("t5_wr_addr_hold", 32'(wr_ddr_addr), 32'd0);
    chk("t5_used_hold", ddr_used, 32'd0);

    // sch_en low holds off grants; raising it releases a write.
    sch_en = 1'b0; wfifo_cnt = 12'd64;
    quiet(5, "t7_hold");
    sch_en = 1'b1;
    run_burst(1'b1, 32'h000, 32'd64, 8, "t7_wr");
    wfifo_cnt = 12'd0;
`ifdef DDR_FIFO_SCH_STAT_EN
    exp_wr_cnt = 32'd1;
`else
    exp_wr_cnt = 32'd0;
`endif
    chk("t7_wr_cnt", wr_burst_cnt, exp_wr_cnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
